// File: rtl/cipher_fifo_pkg.sv
// Shared defaults and helpers for the key-scrambled FIFO.
// The scramble XOR is applied identically on the write and read paths.
package cipher_fifo_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int DEPTH_DEF      = 48;
    // Widest word the scramble helper accepts; callers zero-extend into it.
    localparam int SCRAMBLE_MAX_W = 512;

    typedef logic [SCRAMBLE_MAX_W-1:0] scramble_word_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic scramble_word_t scramble(input scramble_word_t data,
                                                input scramble_word_t key);
        return data ^ key;
    endfunction

endpackage

// File: rtl/cipher_fifo_ptr.sv
// Wrap-around pointer over 0..DEPTH-1 with an increment enable.
// Increment is expected to already include the clock-enable qualification.
module cipher_fifo_ptr
    import cipher_fifo_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_q;

    always_comb begin
        // NOTE: assign the default first so no path leaves ptr_d unassigned (no latch).
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/cipher_fifo.sv
// Key-scrambled circular FIFO with registered status, almost-full level
// and sticky overflow/underflow flags; read data has one cycle of latency.
module cipher_fifo
    import cipher_fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LAST_LVL = DEPTH - 1,
    parameter int CNT_W    = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Cen,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] Cipher_key,
    input  logic              clr_err,
    output logic [DATA_W-1:0] QUEUE_Data_Out,
    output logic              QUEUE_Data_Valid,
    output logic              QUEUE_Empty,
    output logic              QUEUE_Full,
    output logic              QUEUE_Last,
    output logic [CNT_W-1:0]  QUEUE_Count,
    output logic              QUEUE_Overflow,
    output logic              QUEUE_Underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    logic [CNT_W-1:0]  count_d,    count_q;
    logic              empty_d,    empty_q;
    logic              full_d,     full_q;
    logic              last_d,     last_q;
    logic [DATA_W-1:0] data_out_d, data_out_q;
    logic              valid_d,    valid_q;
    logic              ovf_d,      ovf_q;
    logic              udf_d,      udf_q;

    // Accepts use the registered flags, so status never depends combinationally on requests.
    assign rd_acc = Cen & rd_en & ~empty_q;
    assign wr_acc = Cen & wr_en & (~full_q | rd_acc);

    cipher_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (reset),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    cipher_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (reset),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (Cen) begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            valid_d = rd_acc;
            if (rd_acc) begin
                data_out_d = DATA_W'(scramble(SCRAMBLE_MAX_W'(mem[rd_ptr]),
                                              SCRAMBLE_MAX_W'(Cipher_key)));
            end

            // A new error on the same edge as clr_err leaves the flag set.
            ovf_d = (wr_en & ~wr_acc) | (ovf_q & ~clr_err);
            udf_d = (rd_en & ~rd_acc) | (udf_q & ~clr_err);
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
        last_d  = (count_d >= CNT_W'(LAST_LVL)) && !full_d;
    end

    // NOTE: storage has no reset; after reset the pointers make old words unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= DATA_W'(scramble(SCRAMBLE_MAX_W'(Data_in),
                                            SCRAMBLE_MAX_W'(Cipher_key)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            last_q     <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            last_q     <= last_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign QUEUE_Data_Out   = data_out_q;
    assign QUEUE_Data_Valid = valid_q;
    assign QUEUE_Empty      = empty_q;
    assign QUEUE_Full       = full_q;
    assign QUEUE_Last       = last_q;
    assign QUEUE_Count      = count_q;
    assign QUEUE_Overflow   = ovf_q;
    assign QUEUE_Underflow  = udf_q;

endmodule

// File: tb/tb_cipher_fifo.sv
// Directed bench for cipher_fifo: a queue of stored scrambled words predicts
// read data, and a small model predicts count, status and error flags.
module tb_cipher_fifo;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 48;
    localparam int LAST_LVL = DEPTH - 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              Cen;
    logic              wr_en;
    logic [DATA_W-1:0] Data_in;
    logic              rd_en;
    logic [DATA_W-1:0] Cipher_key;
    logic              clr_err;
    logic [DATA_W-1:0] QUEUE_Data_Out;
    logic              QUEUE_Data_Valid;
    logic              QUEUE_Empty;
    logic              QUEUE_Full;
    logic              QUEUE_Last;
    logic [CNT_W-1:0]  QUEUE_Count;
    logic              QUEUE_Overflow;
    logic              QUEUE_Underflow;

    cipher_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .LAST_LVL (LAST_LVL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Cen              (Cen),
        .wr_en            (wr_en),
        .Data_in          (Data_in),
        .rd_en            (rd_en),
        .Cipher_key       (Cipher_key),
        .clr_err          (clr_err),
        .QUEUE_Data_Out   (QUEUE_Data_Out),
        .QUEUE_Data_Valid (QUEUE_Data_Valid),
        .QUEUE_Empty      (QUEUE_Empty),
        .QUEUE_Full       (QUEUE_Full),
        .QUEUE_Last       (QUEUE_Last),
        .QUEUE_Count      (QUEUE_Count),
        .QUEUE_Overflow   (QUEUE_Overflow),
        .QUEUE_Underflow  (QUEUE_Underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: scrambled words as stored; descrambled with the key at read time.
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] exp_dout  = '0;
    logic              exp_valid = 1'b0;
    logic              exp_ovf   = 1'b0;
    logic              exp_udf   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        int c;
        c = sb.size();
        check({tag, " count"}, 64'(QUEUE_Count), 64'(c));
        check({tag, " empty"}, 64'(QUEUE_Empty), 64'(c == 0));
        check({tag, " full"},  64'(QUEUE_Full),  64'(c == DEPTH));
        check({tag, " last"},  64'(QUEUE_Last),  64'((c >= LAST_LVL) && (c != DEPTH)));
        check({tag, " valid"}, 64'(QUEUE_Data_Valid), 64'(exp_valid));
        check({tag, " dout"},  64'(QUEUE_Data_Out),   64'(exp_dout));
        check({tag, " ovf"},   64'(QUEUE_Overflow),   64'(exp_ovf));
        check({tag, " udf"},   64'(QUEUE_Underflow),  64'(exp_udf));
    endtask

    // One clock edge with the given requests; the model is updated and the DUT checked.
    task automatic step(input string tag, input logic w, input logic [DATA_W-1:0] d,
                        input logic r);
        logic ra, wa;
        wr_en   = w;
        Data_in = d;
        rd_en   = r;
        ra = Cen && r && (sb.size() != 0);
        wa = Cen && w && ((sb.size() < DEPTH) || ra);
        @(posedge clk);
        #1;
        if (Cen) begin
            exp_valid = ra;
            if (ra) exp_dout = sb.pop_front() ^ Cipher_key;
            if (wa) sb.push_back(d ^ Cipher_key);
            exp_ovf = (w && !wa) || (exp_ovf && !clr_err);
            exp_udf = (r && !ra) || (exp_udf && !clr_err);
        end
        check_state(tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        Cen        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        Data_in    = '0;
        Cipher_key = '0;
        clr_err    = 1'b0;

        // Reset defaults
        #20;
        check_state("reset");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Scramble round trip with a constant key
        Cipher_key = 32'hA5A5_0F0F;
        step("rt_wr", 1'b1, 32'h1234_5678, 1'b0);
        step("rt_rd", 1'b0, '0, 1'b1);
        check("rt_plain", 64'(QUEUE_Data_Out), 64'h1234_5678);
        step("rt_idle", 1'b0, '0, 1'b0);

        // Key changed between write and read
        step("key_wr", 1'b1, 32'h1234_5678, 1'b0);
        Cipher_key = '0;
        step("key_rd", 1'b0, '0, 1'b1);
        check("key_raw", 64'(QUEUE_Data_Out), 64'hB791_5977);

        // Fill to full, overflow, drain in order
        Cipher_key = 32'hDEAD_BEEF;
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, DATA_W'(i), 1'b0);
        step("ovf_wr", 1'b1, 32'hFFFF_FFFF, 1'b0);
        check("ovf_flag", 64'(QUEUE_Overflow), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, '0, 1'b1);
            check("drain_order", 64'(QUEUE_Data_Out), 64'(i));
        end
        clr_err = 1'b1;
        step("clr_ovf", 1'b0, '0, 1'b0);
        clr_err = 1'b0;

        // Wrap-around at constant fill level of 10
        Cipher_key = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) step("pre10", 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 100; i++) step("wrap", 1'b1, $urandom, 1'b1);

        // Full with both requested
        for (int i = 10; i < DEPTH; i++) step("refill", 1'b1, $urandom, 1'b0);
        step("full_both", 1'b1, 32'h5555_AAAA, 1'b1);
        check("full_both_cnt", 64'(QUEUE_Count), 64'(DEPTH));

        // Empty with both requested
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, '0, 1'b1);
        step("empty_both", 1'b1, 32'h0F0F_1234, 1'b1);
        check("empty_both_udf", 64'(QUEUE_Underflow), 64'd1);
        step("ovf_again", 1'b0, '0, 1'b1);
        step("ovf_again_rd", 1'b0, '0, 1'b1);
        clr_err = 1'b1;
        step("clr_both", 1'b0, '0, 1'b0);
        clr_err = 1'b0;
        check("clr_udf", 64'(QUEUE_Underflow), 64'd0);

        // Clock enable low freezes everything, including a high valid
        for (int i = 0; i < 3; i++) step("cen_pre", 1'b1, 32'hC0DE_0000 + DATA_W'(i), 1'b0);
        step("cen_rd", 1'b0, '0, 1'b1);
        Cen = 1'b0;
        for (int i = 0; i < 5; i++) step("cen_off", 1'b1, 32'hDEAD_0000, 1'b1);
        Cen = 1'b1;
        step("cen_on", 1'b0, '0, 1'b1);

        // Asynchronous reset at count 20
        while (sb.size() < 20) step("to20", 1'b1, $urandom, 1'b0);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        check_state("async_rst");
        #2 reset = 1'b0;
        step("post_wr", 1'b1, 32'h600D_CAFE, 1'b0);
        step("post_rd", 1'b0, '0, 1'b1);
        check("post_data", 64'(QUEUE_Data_Out), 64'h600D_CAFE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout: simulation did not finish");
    end

endmodule
